// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect tone player: state and note encodings,
// default note dividers and note length, counter widths and the silent DAC level.
package sfx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_NOTE_A = 2'd1,
        ST_NOTE_B = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NOTE_C = 2'd0,
        NOTE_D = 2'd1,
        NOTE_E = 2'd2,
        NOTE_G = 2'd3
    } note_e;

    localparam int unsigned DIV_DO_DEF   = 2986;
    localparam int unsigned DIV_RE_DEF   = 2660;
    localparam int unsigned DIV_MI_DEF   = 2369;
    localparam int unsigned DIV_SOL_DEF  = 1993;
    localparam int unsigned NOTE_LEN_DEF = 5000000;

    localparam int LEN_W   = 23;
    localparam int DIV_W   = 12;
    localparam int PHASE_W = 5;

    localparam logic [3:0] IDLE_LVL = 4'h8;

endpackage

// File: rtl/sine_rom_32x4.sv
// One full sine period in 32 steps, 4-bit samples centred on DAC midscale (8).
module sine_rom_32x4
    import sfx_pkg::*;
(
    input  logic [PHASE_W-1:0] addr,
    output logic [3:0]         sample
);

    // Table lookup: round(8 + 7*sin(2*pi*addr/32))
    always_comb begin
        sample = IDLE_LVL;
        case (addr)
            5'd0:  sample = 4'd8;
            5'd1:  sample = 4'd9;
            5'd2:  sample = 4'd11;
            5'd3:  sample = 4'd12;
            5'd4:  sample = 4'd13;
            5'd5:  sample = 4'd14;
            5'd6:  sample = 4'd14;
            5'd7:  sample = 4'd15;
            5'd8:  sample = 4'd15;
            5'd9:  sample = 4'd15;
            5'd10: sample = 4'd14;
            5'd11: sample = 4'd14;
            5'd12: sample = 4'd13;
            5'd13: sample = 4'd12;
            5'd14: sample = 4'd11;
            5'd15: sample = 4'd9;
            5'd16: sample = 4'd8;
            5'd17: sample = 4'd7;
            5'd18: sample = 4'd5;
            5'd19: sample = 4'd4;
            5'd20: sample = 4'd3;
            5'd21: sample = 4'd2;
            5'd22: sample = 4'd2;
            5'd23: sample = 4'd1;
            5'd24: sample = 4'd1;
            5'd25: sample = 4'd1;
            5'd26: sample = 4'd2;
            5'd27: sample = 4'd2;
            5'd28: sample = 4'd3;
            5'd29: sample = 4'd4;
            5'd30: sample = 4'd5;
            5'd31: sample = 4'd7;
            default: sample = IDLE_LVL;
        endcase
    end

endmodule

// File: rtl/sfx_tone_player.sv
// Turns paddle/brick hit flags into short sine tone bursts on the 4-bit DAC output.
// Brick hits play E then G, paddle hits play C; any new hit restarts the burst.
module sfx_tone_player
    import sfx_pkg::*;
#(
    parameter int unsigned DIV_DO   = DIV_DO_DEF,
    parameter int unsigned DIV_RE   = DIV_RE_DEF,
    parameter int unsigned DIV_MI   = DIV_MI_DEF,
    parameter int unsigned DIV_SOL  = DIV_SOL_DEF,
    parameter int unsigned NOTE_LEN = NOTE_LEN_DEF
)(
    input  logic       clk50mhz,
    input  logic       reset_button,
    input  logic       play_sound1,
    input  logic       play_sound2,
    input  logic       mute,
    output logic [3:0] tono,
    output logic       busy,
    output logic [1:0] note_id
);

    localparam logic [DIV_W-1:0] DIV_DO_LAST  = DIV_W'(DIV_DO - 1);
    localparam logic [DIV_W-1:0] DIV_RE_LAST  = DIV_W'(DIV_RE - 1);
    localparam logic [DIV_W-1:0] DIV_MI_LAST  = DIV_W'(DIV_MI - 1);
    localparam logic [DIV_W-1:0] DIV_SOL_LAST = DIV_W'(DIV_SOL - 1);
    localparam logic [LEN_W-1:0] LEN_LAST     = LEN_W'(NOTE_LEN - 1);

    logic [2:0] sync1_q, sync2_q;
    logic       trig1_q, trig2_q;

    state_e             state_q, state_d;
    note_e              note_q, note_d;
    logic               two_note_q, two_note_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [3:0]         tono_q, tono_d;
    logic               busy_q, busy_d;
    logic [1:0]         note_id_q, note_id_d;

    logic [DIV_W-1:0]   div_last;
    logic [3:0]         rom_sample;

    sine_rom_32x4 u_rom (
        .addr   (phase_q),
        .sample (rom_sample)
    );

    // Two-flop synchronizers plus a history flop; triggers are registered rising edges
    always_ff @(posedge clk50mhz or posedge reset_button) begin
        if (reset_button) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            trig1_q <= 1'b0;
            trig2_q <= 1'b0;
        end else begin
            sync1_q <= {sync1_q[1:0], play_sound1};
            sync2_q <= {sync2_q[1:0], play_sound2};
            trig1_q <= sync1_q[1] & ~sync1_q[2];
            trig2_q <= sync2_q[1] & ~sync2_q[2];
        end
    end

    // Phase-step divider terminal value for the note currently sounding
    always_comb begin
        div_last = DIV_DO_LAST;
        case (note_q)
            NOTE_C:  div_last = DIV_DO_LAST;
            NOTE_D:  div_last = DIV_RE_LAST;
            NOTE_E:  div_last = DIV_MI_LAST;
            NOTE_G:  div_last = DIV_SOL_LAST;
            default: div_last = DIV_DO_LAST;
        endcase
    end

    // Sequencer next state, counters and registered-output next values
    always_comb begin
        state_d    = state_q;
        note_d     = note_q;
        two_note_d = two_note_q;
        len_d      = len_q;
        div_d      = div_q;
        phase_d    = phase_q;
        if (trig2_q) begin
            state_d    = ST_NOTE_A;
            note_d     = NOTE_E;
            two_note_d = 1'b1;
            len_d      = {LEN_W{1'b0}};
            div_d      = {DIV_W{1'b0}};
            phase_d    = {PHASE_W{1'b0}};
        end else if (trig1_q) begin
            state_d    = ST_NOTE_A;
            note_d     = NOTE_C;
            two_note_d = 1'b0;
            len_d      = {LEN_W{1'b0}};
            div_d      = {DIV_W{1'b0}};
            phase_d    = {PHASE_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    note_d     = NOTE_C;
                    two_note_d = 1'b0;
                    len_d      = {LEN_W{1'b0}};
                    div_d      = {DIV_W{1'b0}};
                    phase_d    = {PHASE_W{1'b0}};
                end
                ST_NOTE_A, ST_NOTE_B: begin
                    if (len_q == LEN_LAST) begin
                        len_d   = {LEN_W{1'b0}};
                        div_d   = {DIV_W{1'b0}};
                        phase_d = {PHASE_W{1'b0}};
                        if ((state_q == ST_NOTE_A) && two_note_q) begin
                            state_d = ST_NOTE_B;
                            note_d  = NOTE_G;
                        end else begin
                            state_d    = ST_IDLE;
                            note_d     = NOTE_C;
                            two_note_d = 1'b0;
                        end
                    end else begin
                        len_d = len_q + 23'd1;
                        if (div_q == div_last) begin
                            div_d   = {DIV_W{1'b0}};
                            phase_d = phase_q + 5'd1;
                        end else begin
                            div_d = div_q + 12'd1;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    note_d     = NOTE_C;
                    two_note_d = 1'b0;
                    len_d      = {LEN_W{1'b0}};
                    div_d      = {DIV_W{1'b0}};
                    phase_d    = {PHASE_W{1'b0}};
                end
            endcase
        end

        busy_d    = (state_d != ST_IDLE);
        note_id_d = busy_d ? note_d : NOTE_C;
        // Sample follows the phase of the current cycle, giving one cycle of latency
        tono_d    = (mute || (state_q == ST_IDLE)) ? IDLE_LVL : rom_sample;
    end

    // Sequencer state, counters and output registers
    always_ff @(posedge clk50mhz or posedge reset_button) begin
        if (reset_button) begin
            state_q    <= ST_IDLE;
            note_q     <= NOTE_C;
            two_note_q <= 1'b0;
            len_q      <= {LEN_W{1'b0}};
            div_q      <= {DIV_W{1'b0}};
            phase_q    <= {PHASE_W{1'b0}};
            tono_q     <= IDLE_LVL;
            busy_q     <= 1'b0;
            note_id_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            note_q     <= note_d;
            two_note_q <= two_note_d;
            len_q      <= len_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            tono_q     <= tono_d;
            busy_q     <= busy_d;
            note_id_q  <= note_id_d;
        end
    end

    assign tono    = tono_q;
    assign busy    = busy_q;
    assign note_id = note_id_q;

endmodule

// File: tb/tb_sfx_tone_player.sv
// Directed bench for sfx_tone_player with short notes (NOTE_LEN=40) and small dividers.
module tb_sfx_tone_player;

    logic       clk50mhz = 1'b0;
    logic       reset_button;
    logic       play_sound1;
    logic       play_sound2;
    logic       mute;
    logic [3:0] tono;
    logic       busy;
    logic [1:0] note_id;

    int checks = 0;
    int errors = 0;

    localparam int M_C  = 0;
    localparam int M_EG = 1;
    localparam int M_RT = 2;

    logic [3:0] sine_tab [32] = '{
        4'd8, 4'd9, 4'd11, 4'd12, 4'd13, 4'd14, 4'd14, 4'd15,
        4'd15, 4'd15, 4'd14, 4'd14, 4'd13, 4'd12, 4'd11, 4'd9,
        4'd8, 4'd7, 4'd5, 4'd4, 4'd3, 4'd2, 4'd2, 4'd1,
        4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7};

    sfx_tone_player #(
        .DIV_DO   (4),
        .DIV_RE   (5),
        .DIV_MI   (3),
        .DIV_SOL  (2),
        .NOTE_LEN (40)
    ) dut (
        .clk50mhz     (clk50mhz),
        .reset_button (reset_button),
        .play_sound1  (play_sound1),
        .play_sound2  (play_sound2),
        .mute         (mute),
        .tono         (tono),
        .busy         (busy),
        .note_id      (note_id)
    );

    always #5 clk50mhz = ~clk50mhz;

    // k = cycles since the first note became active (busy first high at k=0)
    function automatic logic m_busy(input int mode, input int k);
        if (k < 0) return 1'b0;
        case (mode)
            M_C:     return k < 40;
            M_EG:    return k < 80;
            M_RT:    return k < 63;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] m_note(input int mode, input int k);
        if (!m_busy(mode, k)) return 2'd0;
        case (mode)
            M_C:     return 2'd0;
            M_EG:    return (k < 40) ? 2'd2 : 2'd3;
            M_RT:    return (k < 23) ? 2'd2 : 2'd0;
            default: return 2'd0;
        endcase
    endfunction

    function automatic int m_phase(input int mode, input int k);
        case (mode)
            M_C:     return (k / 4) % 32;
            M_EG:    return (k < 40) ? k / 3 : (k - 40) / 2;
            M_RT:    return (k < 23) ? k / 3 : (k - 23) / 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] m_tono(input int mode, input int k, input logic muted);
        if (muted || !m_busy(mode, k - 1)) return 4'd8;
        return sine_tab[m_phase(mode, k - 1)];
    endfunction

    task automatic test_reset();
        reset_button = 1'b1;
        play_sound1 = 1'b0;
        play_sound2 = 1'b0;
        mute = 1'b0;
        repeat (3) @(negedge clk50mhz);
        checks++;
        if (tono !== 4'd8 || busy !== 1'b0 || note_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: tono=%0d busy=%0d note_id=%0d, want 8 0 0", tono, busy, note_id);
        end
        reset_button = 1'b0;
        // start a C burst and reset it in the middle
        play_sound1 = 1'b1;
        for (int c = 1; c <= 20; c++) @(negedge clk50mhz);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy: busy=%0d want 1", busy);
        end
        reset_button = 1'b1;
        play_sound1 = 1'b0;
        #1;
        checks++;
        if (tono !== 4'd8 || busy !== 1'b0 || note_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_async: tono=%0d busy=%0d note_id=%0d, want 8 0 0", tono, busy, note_id);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk50mhz);
            if (c == 2) reset_button = 1'b0;
            checks++;
            if (tono !== 4'd8 || busy !== 1'b0 || note_id !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold: c=%0d tono=%0d busy=%0d note_id=%0d, want 8 0 0", c, tono, busy, note_id);
            end
        end
    endtask

    task automatic test_paddle(input logic muted);
        mute = muted;
        play_sound1 = 1'b1;
        for (int c = 1; c <= 260; c++) begin
            int k;
            @(negedge clk50mhz);
            k = c - 4;
            checks++;
            if (busy !== m_busy(M_C, k) || note_id !== m_note(M_C, k) || tono !== m_tono(M_C, k, muted)) begin
                errors++;
                $display("FAIL paddle(mute=%0d) k=%0d: busy=%0d note=%0d tono=%0d, want %0d %0d %0d",
                         muted, k, busy, note_id, tono, m_busy(M_C, k), m_note(M_C, k), m_tono(M_C, k, muted));
            end
            if (c == 200) play_sound1 = 1'b0;
        end
        mute = 1'b0;
    endtask

    task automatic test_brick(input logic both);
        play_sound2 = 1'b1;
        if (both) play_sound1 = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            int k;
            @(negedge clk50mhz);
            k = c - 4;
            checks++;
            if (busy !== m_busy(M_EG, k) || note_id !== m_note(M_EG, k) || tono !== m_tono(M_EG, k, 1'b0)) begin
                errors++;
                $display("FAIL brick(both=%0d) k=%0d: busy=%0d note=%0d tono=%0d, want %0d %0d %0d",
                         both, k, busy, note_id, tono, m_busy(M_EG, k), m_note(M_EG, k), m_tono(M_EG, k, 1'b0));
            end
            if (both && busy === 1'b1) begin
                checks++;
                if (note_id === 2'd0) begin
                    errors++;
                    $display("FAIL both_no_c k=%0d: note_id=%0d want nonzero", k, note_id);
                end
            end
            if (c == 3) begin
                play_sound1 = 1'b0;
                play_sound2 = 1'b0;
            end
        end
    endtask

    task automatic test_retrigger();
        int busy_cycles = 0;
        play_sound2 = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            int k;
            @(negedge clk50mhz);
            k = c - 4;
            if (busy === 1'b1) busy_cycles++;
            checks++;
            if (busy !== m_busy(M_RT, k) || note_id !== m_note(M_RT, k) || tono !== m_tono(M_RT, k, 1'b0)) begin
                errors++;
                $display("FAIL retrigger k=%0d: busy=%0d note=%0d tono=%0d, want %0d %0d %0d",
                         k, busy, note_id, tono, m_busy(M_RT, k), m_note(M_RT, k), m_tono(M_RT, k, 1'b0));
            end
            if (c == 3) play_sound2 = 1'b0;
            if (c == 23) play_sound1 = 1'b1;
            if (c == 26) play_sound1 = 1'b0;
        end
        checks++;
        if (busy_cycles < 62 || busy_cycles > 64) begin
            errors++;
            $display("FAIL retrigger_len: busy for %0d cycles, want 63 +-1", busy_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_paddle(1'b0);
        test_brick(1'b0);
        test_brick(1'b1);
        test_retrigger();
        test_paddle(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
